bitwise_ones_counter: RTL and testbench
=======================================

# bitwise_ones_counter

Registered population-count block: counts the number of `1` bits in an input word and presents the count one clock later. It serves as a small datapath utility for bit-density checks, for example on flag vectors or mask weights, and feeds any downstream logic that needs a bit-count of a captured word. The default configuration is a 4-bit input with a 3-bit count, covering counts 0..4.

## Interface
Parameters:
- `WIDTH`, default 4: input word width, legal range 1..64.
- `OUT_W`, default `$clog2(WIDTH+1)` (3 when `WIDTH`=4): count width. It is derived from `WIDTH` and must not be overridden independently.

Ports:
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `In`, input, `WIDTH`: word to be counted.
- `in_valid`, input, 1: `In` is sampled when this is high.
- `out`, output, `OUT_W`: number of set bits in the last accepted `In`, unsigned.
- `out_valid`, output, 1: high for exactly one cycle after each accepted word.

## Operation
- Combinational count: sum over i of `In[i]`, computed with a balanced adder tree.
  - Each tree level's partial sums are sized to hold the maximum count at that level, so no intermediate overflow occurs.
  - The final sum is zero-extended or truncated to `OUT_W` losslessly, because `OUT_W` always covers `WIDTH`.
- At a rising edge with `in_valid`=1: `out` <= count(`In`), and `out_valid` <= 1.
- At a rising edge with `in_valid`=0: `out` holds its previous value, and `out_valid` <= 0.
- `out` must equal the popcount exactly for every input pattern. Required results include:
  - all-zero input gives 0;
  - all-ones input gives `WIDTH`;
  - 4'b1011 gives 3.
- No X-propagation masking: an X on `In` may propagate to `out`.
- There is no backpressure. Every accepted word produces a result.

## Timing
- Latency is 1 cycle from `In`/`in_valid` sampled at edge N to `out`/`out_valid` visible after edge N.
- Throughput is one word per cycle, and back-to-back valid inputs are supported.
- Reset values: `out`=0 and `out_valid`=0. These are applied at the first rising edge with `rst`=1.
- Reset has priority over `in_valid`. A word presented in the same cycle that `rst` is high is discarded.
- Reset asserted mid-stream: the in-flight result is lost.
  - `out_valid` is 0 in the cycle after the reset edge.
  - The first word accepted after `rst` deasserts produces its result normally.
- `in_valid` held low indefinitely: `out` retains the last count, and `out_valid` stays 0.

## Structure
- Shared package `bitcount_pkg`:
  - function `count_w(width)`, which returns `$clog2(width+1)` with a minimum of 1;
  - default constant `BITCOUNT_DEFAULT_WIDTH` = 4.
- Sub-module `ones_count_tree`: purely combinational, parameterized by `WIDTH`.
  - It uses a generate-built pairwise adder tree with ceil(log2 `WIDTH`) levels.
  - Odd leftover operands pass through to the next level.
  - It contains no clock.
- The top level `bitwise_ones_counter` instantiates `ones_count_tree` and holds the `out`/`out_valid` registers and the reset logic.

## Test plan
- Exhaustive check, `WIDTH`=4: drive `In`=0..15, one per cycle, with `in_valid`=1. Each `out` equals popcount one cycle later:
  - 0→0, 1→1, 3→2, 7→3, 15→4, 10→2, 11→3.
- Reset: hold `rst`=1 for 2 cycles → `out`=0 and `out_valid`=0. Then drive `In`=4'b1111 with `in_valid`=1 and `rst` still 1 → `out` stays 0. Release `rst` → the next valid word counts normally.
- Hold behaviour: accept `In`=4'b0111 (count 3), then drive `in_valid`=0 with `In`=4'b0000 for 5 cycles → `out` stays 3 and `out_valid` stays 0.
- Back-to-back words: drive `in_valid`=1 continuously with `In` sequence 0000, 1000, 1100, 1110, 1111 → `out` sequence 0, 1, 2, 3, 4 on consecutive cycles, with `out_valid` high throughout.
- Parameter scaling, `WIDTH`=8 (`OUT_W`=4): 8'hFF→8, 8'h00→0, 8'hA5→4, 8'h80→1. Also `WIDTH`=1 (`OUT_W`=1): 1→1, 0→0.
- Random: 1000 random `WIDTH`=16 words with random `in_valid`, checked against a reference popcount model, including mid-run `rst` pulses.

Source files
------------

// File: rtl/bitcount_pkg.sv
// Shared constants and sizing helper for the population-count blocks.
package bitcount_pkg;

  localparam int BITCOUNT_DEFAULT_WIDTH = 4;

  // Bits needed to hold a count of 0..width, never less than one bit.
  function automatic int count_w(input int width);
    int w;
    w = $clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ones_count_tree.sv
// Combinational population count built as a balanced pairwise adder tree.
// Level 0 holds the individual input bits. Each higher level sums adjacent
// pairs from the level below, and an odd leftover node is passed up unchanged.
// Level l nodes are sized for a maximum count of 2**l, so no partial sum can
// overflow.
module ones_count_tree
  import bitcount_pkg::*;
#(
  parameter int WIDTH = BITCOUNT_DEFAULT_WIDTH,
  parameter int OUT_W = count_w(WIDTH)
) (
  input  logic [WIDTH-1:0] in_word,
  output logic [OUT_W-1:0] count
);

  localparam int LEVELS = (WIDTH <= 1) ? 0 : $clog2(WIDTH);

  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    localparam int N = (WIDTH + (1 << l) - 1) >> l;
    localparam int W = $clog2((1 << l) + 1);
    logic [W-1:0] node [N];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_bit
        assign node[i] = in_word[i];
      end
    end else begin : g_sum
      localparam int NP = (WIDTH + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar i = 0; i < N; i++) begin : g_node
        if (2 * i + 1 < NP) begin : g_add
          assign node[i] = W'(lvl[l-1].node[2*i]) + W'(lvl[l-1].node[2*i+1]);
        end else begin : g_pass
          assign node[i] = W'(lvl[l-1].node[2*i]);
        end
      end
    end
  end

  // The root is at least as wide as OUT_W, which always covers WIDTH, so the
  // cast never discards a set bit.
  assign count = OUT_W'(lvl[LEVELS].node[0]);

endmodule

// File: rtl/bitwise_ones_counter.sv
// Registered population count: the result appears one cycle after the word is
// accepted, and out_valid pulses once for each accepted word.
module bitwise_ones_counter
  import bitcount_pkg::*;
#(
  parameter int WIDTH = BITCOUNT_DEFAULT_WIDTH,
  parameter int OUT_W = count_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_valid
);

  logic [OUT_W-1:0] cnt;
  logic [OUT_W-1:0] out_d, out_q;
  logic             out_valid_d, out_valid_q;

  ones_count_tree #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_tree (
    .in_word (In),
    .count   (cnt)
  );

  // Capture the count on an accepted word; otherwise hold the last count.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    if (in_valid) out_d = cnt;
  end

  // Result registers. Reset wins over in_valid, so a word presented under reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bitwise_ones_counter.sv
// Four counters (WIDTH 1, 4, 8 and 16) share one stimulus stream. Each one
// sees the low bits of a 16-bit word. A model records accepted words in a
// queue, and a monitor pops an entry whenever the 16-bit counter presents
// a result. The monitor then checks every counter against a bit-sum of its
// slice of that word.
module tb_bitwise_ones_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] din = '0;

  always #5 clk = ~clk;

  logic       o1;
  logic [2:0] o4;
  logic [3:0] o8;
  logic [4:0] o16;
  logic       v1, v4, v8, v16;

  bitwise_ones_counter #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .In(din[0:0]), .in_valid(in_valid), .out(o1), .out_valid(v1));
  bitwise_ones_counter #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .In(din[3:0]), .in_valid(in_valid), .out(o4), .out_valid(v4));
  bitwise_ones_counter #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .In(din[7:0]), .in_valid(in_valid), .out(o8), .out_valid(v8));
  bitwise_ones_counter #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .In(din), .in_valid(in_valid), .out(o16), .out_valid(v16));

  int          checks = 0;
  int          failures = 0;
  logic [15:0] q[$];
  bit          exp_vld = 1'b0;
  bit          clr = 1'b0;
  bit          started = 1'b0;
  logic [15:0] last_word = '0;

  // Reference count: number of set bits among the low n bits.
  function automatic int pc(input logic [15:0] w, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) if (w[i] === 1'b1) s++;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (word %h) at %0t", nm, act, exp, last_word, $time);
    end
  endtask

  // Model: reset clears anything pending; an accepted word is queued.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      exp_vld = 1'b0;
      clr     = 1'b1;
      started = 1'b1;
    end else begin
      exp_vld = in_valid;
      if (in_valid) q.push_back(din);
    end
  end

  // Monitor: sample away from the active edge and compare against the model.
  always @(negedge clk) begin
    if (started) begin
      if (clr) begin
        last_word = '0;
        clr       = 1'b0;
      end
      if (v16 === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop: result presented with nothing expected at %0t", $time);
        end else begin
          last_word = q.pop_front();
        end
      end
      chk("vld_w1",  {31'b0, v1},  {31'b0, exp_vld});
      chk("vld_w4",  {31'b0, v4},  {31'b0, exp_vld});
      chk("vld_w8",  {31'b0, v8},  {31'b0, exp_vld});
      chk("vld_w16", {31'b0, v16}, {31'b0, exp_vld});
      chk("cnt_w1",  {31'b0, o1},  pc(last_word, 1));
      chk("cnt_w4",  {29'b0, o4},  pc(last_word, 4));
      chk("cnt_w8",  {28'b0, o8},  pc(last_word, 8));
      chk("cnt_w16", {27'b0, o16}, pc(last_word, 16));
    end
  end

  task automatic drive(input logic r, input logic v, input logic [15:0] w);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    din      = w;
  endtask

  initial begin
    logic [15:0] seq [5];
    logic [15:0] w8p [4];
    seq = '{16'h0000, 16'h0008, 16'h000C, 16'h000E, 16'h000F};
    w8p = '{16'h00FF, 16'h0000, 16'h00A5, 16'h0080};

    // Reset held for two cycles, then a word offered while reset is still high.
    drive(1'b1, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 16'h000F);
    drive(1'b0, 1'b1, 16'h000B);

    // Exhaustive sweep of the 4-bit space.
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 16'(i));

    // Hold: the last count stays while in_valid is low.
    drive(1'b0, 1'b1, 16'h0007);
    repeat (5) drive(1'b0, 1'b0, 16'h0000);

    // Back-to-back ramp of set bits.
    foreach (seq[i]) drive(1'b0, 1'b1, seq[i]);

    // Wider patterns, including all ones.
    foreach (w8p[i]) drive(1'b0, 1'b1, w8p[i]);
    drive(1'b0, 1'b1, 16'hFFFF);
    drive(1'b0, 1'b1, 16'h0001);
    drive(1'b0, 1'b0, 16'h0000);

    // Random words, random valids and occasional reset pulses.
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 16'($urandom));
    end

    drive(1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
